// File: rtl/alu_seq_pkg.sv
// Shared opcode, unit-enable and state definitions for the ALU sequencer.
// Used by alu_op_decode and alu_sequencer.
package alu_seq_pkg;

    localparam logic [3:0] FUNC_ADD = 4'd3;
    localparam logic [3:0] FUNC_SUB = 4'd4;
    localparam logic [3:0] FUNC_XOR = 4'd5;
    localparam logic [3:0] FUNC_OR  = 4'd6;
    localparam logic [3:0] FUNC_AND = 4'd7;
    localparam logic [3:0] FUNC_DIV = 4'd8;
    localparam logic [3:0] FUNC_MOD = 4'd9;

    localparam logic [6:0] EN_NONE = 7'b0000000;
    localparam logic [6:0] EN_XOR  = 7'b1000000;
    localparam logic [6:0] EN_ADD  = 7'b0100000;
    localparam logic [6:0] EN_SUB  = 7'b0010000;
    localparam logic [6:0] EN_AND  = 7'b0001000;
    localparam logic [6:0] EN_OR   = 7'b0000100;
    localparam logic [6:0] EN_DIV  = 7'b0000010;
    localparam logic [6:0] EN_MOD  = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: one-hot unit enable, multi-cycle flag and
// illegal-opcode flag for a 4-bit function code.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] i_func,
    output logic [6:0] o_enables,
    output logic       o_multi,
    output logic       o_illegal
);

    always_comb begin
        o_enables = EN_NONE;
        o_multi   = 1'b0;
        o_illegal = 1'b0;
        case (i_func)
            FUNC_ADD: o_enables = EN_ADD;
            FUNC_SUB: o_enables = EN_SUB;
            FUNC_XOR: o_enables = EN_XOR;
            FUNC_OR:  o_enables = EN_OR;
            FUNC_AND: o_enables = EN_AND;
            FUNC_DIV: begin
                o_enables = EN_DIV;
                o_multi   = 1'b1;
            end
            FUNC_MOD: begin
                o_enables = EN_MOD;
                o_multi   = 1'b1;
            end
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// IDLE/EXEC/DONE sequencer driving one-hot ALU unit enables and a response
// handshake. Optional div/mod watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_func,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [6:0]       enables,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             unit_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic             busy
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("alu_sequencer: TIMEOUT must be at least 1");
    end

    state_t           r_state;
    logic [6:0]       r_enables;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_multi;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_err;

    logic [6:0] w_enables;
    logic       w_multi;
    logic       w_illegal;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_tmo_cnt;
`endif

    alu_op_decode u_decode (
        .i_func    (req_func),
        .o_enables (w_enables),
        .o_multi   (w_multi),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_enables    <= EN_NONE;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_multi      <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
            r_tmo_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op_a  <= req_a;
                        r_op_b  <= req_b;
                        r_multi <= w_multi;
`ifdef ALU_SEQ_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                        // Illegal opcodes skip EXEC so no unit is ever enabled.
                        if (w_illegal) begin
                            r_rsp_result <= '0;
                            r_rsp_err    <= 1'b1;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= ST_DONE;
                        end else begin
                            r_enables <= w_enables;
                            r_rsp_err <= 1'b0;
                            r_state   <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    // unit_done is checked before expiry so a late finish still wins.
                    if (!r_multi || unit_done) begin
                        r_rsp_result <= alu_result;
                        r_enables    <= EN_NONE;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_DONE;
                    end
`ifdef ALU_SEQ_TIMEOUT_EN
                    else if (r_tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_rsp_result <= '0;
                        r_rsp_err    <= 1'b1;
                        r_enables    <= EN_NONE;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_enables   <= EN_NONE;
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign enables    = r_enables;
    assign op_a       = r_op_a;
    assign op_b       = r_op_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed and randomized ops against
// a transaction-level reference model; timeout cases run when ALU_SEQ_TIMEOUT_EN is set.
module tb_alu_sequencer;

    localparam int W   = 8;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_func;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [6:0]   enables;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] alu_result;
    logic         unit_done;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_err;
    logic         busy;

    logic [3:0]   tb_func;
    int           checks   = 0;
    int           failures = 0;

    alu_sequencer #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_func   (req_func),
        .req_a      (req_a),
        .req_b      (req_b),
        .enables    (enables),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_result (alu_result),
        .unit_done  (unit_done),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        case (f)
            4'd3: return a + b;
            4'd4: return a - b;
            4'd5: return a ^ b;
            4'd6: return a | b;
            4'd7: return a & b;
            4'd8: return (b == 0) ? '1 : a / b;
            4'd9: return (b == 0) ? a : a % b;
            default: return 8'hA5;
        endcase
    endfunction

    function automatic logic [6:0] ref_onehot(input logic [3:0] f);
        case (f)
            4'd5: return 7'b1000000;
            4'd3: return 7'b0100000;
            4'd4: return 7'b0010000;
            4'd7: return 7'b0001000;
            4'd6: return 7'b0000100;
            4'd8: return 7'b0000010;
            4'd9: return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    // Datapath stand-in: result follows the registered operands.
    assign alu_result = ref_alu(tb_func, op_a, op_b);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // done_lat = 0 on div/mod means unit_done never arrives.
    task automatic run_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int done_lat, input int ready_lat);
        bit           legal  = (f >= 4'd3) && (f <= 4'd9);
        bit           multi  = (f == 4'd8) || (f == 4'd9);
        bit           expire = multi && (done_lat == 0);
        int           n_exec = !legal ? 0 : (!multi ? 1 : (expire ? TMO : done_lat));
        logic [6:0]   exp_en = ref_onehot(f);
        logic [W-1:0] exp_res = (legal && !expire) ? ref_alu(f, a, b) : '0;
        logic         exp_err = !legal || expire;

        tb_func = f; req_func = f; req_a = a; req_b = b; req_valid = 1'b1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL idle_ready f=%0d got=%b want=1", f, req_ready); end
        step();
        req_valid = 1'b0; req_func = 4'($urandom); req_a = W'($urandom); req_b = W'($urandom);
        for (int c = 1; c <= n_exec; c++) begin
            checks++; if (enables !== exp_en) begin failures++; $display("FAIL exec_en f=%0d c=%0d got=%b want=%b", f, c, enables, exp_en); end
            checks++; if ({busy, req_ready, rsp_valid} !== 3'b100) begin failures++; $display("FAIL exec_ctl f=%0d c=%0d got=%b want=100", f, c, {busy, req_ready, rsp_valid}); end
            checks++; if ({op_a, op_b} !== {a, b}) begin failures++; $display("FAIL exec_ops f=%0d got=%h want=%h", f, {op_a, op_b}, {a, b}); end
            unit_done = multi ? (c == done_lat) : 1'($urandom);
            step();
            unit_done = 1'b0;
        end
        for (int r = 0; r <= ready_lat; r++) begin
            checks++; if ({rsp_valid, busy, req_ready, enables} !== {3'b110, 7'b0}) begin failures++; $display("FAIL done_ctl f=%0d r=%0d got=%b want=1100000000", f, r, {rsp_valid, busy, req_ready, enables}); end
            checks++; if (rsp_result !== exp_res) begin failures++; $display("FAIL done_res f=%0d r=%0d got=%h want=%h", f, r, rsp_result, exp_res); end
            checks++; if (rsp_err !== exp_err) begin failures++; $display("FAIL done_err f=%0d r=%0d got=%b want=%b", f, r, rsp_err, exp_err); end
            rsp_ready = (r == ready_lat);
            req_valid = 1'b1; req_func = 4'd3;
            unit_done = 1'($urandom);
            step();
        end
        checks++; if ({rsp_valid, busy, req_ready} !== 3'b001) begin failures++; $display("FAIL release f=%0d got=%b want=001", f, {rsp_valid, busy, req_ready}); end
        req_valid = 1'b0; rsp_ready = 1'b0; unit_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_func = '0; req_a = '0; req_b = '0;
        unit_done = 1'b0; rsp_ready = 1'b0; tb_func = '0;
        step(); step();
        checks++; if ({enables, rsp_valid, rsp_err, busy} !== 10'b0) begin failures++; $display("FAIL reset_ctl got=%b want=0", {enables, rsp_valid, rsp_err, busy}); end
        checks++; if ({op_a, op_b, rsp_result} !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", {op_a, op_b, rsp_result}); end
        rst_n = 1'b1;
        step();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_directed();
        run_op(4'd3, 8'h05, 8'h03, 1, 0);
        run_op(4'd8, 8'h64, 8'h07, 5, 0);
        run_op(4'hF, 8'h12, 8'h34, 1, 0);
        run_op(4'd0, 8'h12, 8'h34, 1, 1);
    endtask

    task automatic test_backpressure();
        run_op(4'd5, 8'hC3, 8'h5A, 1, 4);
        run_op(4'd9, 8'hC8, 8'h0B, 3, 4);
    endtask

    task automatic test_reset_in_exec();
        tb_func = 4'd9; req_func = 4'd9; req_a = 8'h77; req_b = 8'h05; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step(); step();
        checks++; if (enables !== 7'b0000001) begin failures++; $display("FAIL mod_en got=%b want=0000001", enables); end
        rst_n = 1'b0;
        step();
        checks++; if ({enables, busy, rsp_valid} !== 9'b0) begin failures++; $display("FAIL abort got=%b want=0", {enables, busy, rsp_valid}); end
        rst_n = 1'b1;
        step();
        checks++; if ({req_ready, busy, rsp_valid} !== 3'b100) begin failures++; $display("FAIL post_reset got=%b want=100", {req_ready, busy, rsp_valid}); end
        run_op(4'd4, 8'h10, 8'h20, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                   int'($urandom_range(1, 10)), int'($urandom_range(0, 3)));
        end
    endtask

`ifdef ALU_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        run_op(4'd9, 8'h33, 8'h04, 0, 0);
        run_op(4'd9, 8'h33, 8'h04, TMO, 0);
        run_op(4'd8, 8'h81, 8'h00, 0, 2);
        run_op(4'd8, 8'h81, 8'h09, TMO - 1, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_in_exec();
`ifdef ALU_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
